// File: rtl/bitmap_frame_loader.sv
// Assembles a 1-bit-per-pixel raster stream into a back buffer and publishes
// whole frames to the front buffer only on vsync, so the display never tears.
module bitmap_frame_loader #(
   parameter int GRID_W   = 128,
   parameter int GRID_H   = 120,
   parameter int PIX_BITS = GRID_W * GRID_H,
   parameter int IDX_W    = 14
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_bit,
   input  logic                in_sof,
   input  logic                vsync,
   output logic [PIX_BITS-1:0] pixel_data_flat,
   output logic                frame_swapped,
   output logic                frame_dropped,
   output logic [7:0]          frame_count
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] FILL = 2'd1;
   localparam logic [1:0] PEND = 2'd2;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_BITS - 1);

   logic [1:0]          state;
   logic [IDX_W-1:0]    wr_idx;
   logic [PIX_BITS-1:0] back_buf;
   logic                accept;

   // A full frame parked in PEND stalls the stream until it has been published.
   assign in_ready = (state != PEND);
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         wr_idx          <= '0;
         back_buf        <= '0;
         pixel_data_flat <= '0;
         frame_swapped   <= 1'b0;
         frame_dropped   <= 1'b0;
         frame_count     <= 8'd0;
      end else begin
         frame_swapped <= 1'b0;
         frame_dropped <= 1'b0;
         case (state)
            IDLE: begin
               // Beats without sof are swallowed here to resynchronise to the next frame.
               if (accept && in_sof) begin
                  back_buf[0] <= in_bit;
                  wr_idx      <= IDX_W'(1);
                  state       <= FILL;
               end
            end
            FILL: begin
               if (accept) begin
                  if (in_sof) begin
                     // Restart: older bits past the new write point get rewritten before completion.
                     frame_dropped <= 1'b1;
                     back_buf[0]   <= in_bit;
                     wr_idx        <= IDX_W'(1);
                  end else begin
                     back_buf[wr_idx] <= in_bit;
                     if (wr_idx == LAST_IDX) begin
                        wr_idx <= '0;
                        state  <= PEND;
                     end else begin
                        wr_idx <= wr_idx + IDX_W'(1);
                     end
                  end
               end
            end
            PEND: begin
               if (vsync) begin
                  pixel_data_flat <= back_buf;
                  frame_swapped   <= 1'b1;
                  frame_count     <= frame_count + 8'd1;
                  state           <= IDLE;
               end
            end
            default: begin
               state  <= IDLE;
               wr_idx <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bitmap_frame_loader.sv
// Directed bench for bitmap_frame_loader: expected front buffers and frame
// counts are queued when vsync is driven and compared when frame_swapped fires.
module tb_bitmap_frame_loader;

   localparam int PIX = 15360;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic           in_bit = 1'b0;
   logic           in_sof = 1'b0;
   logic           vsync = 1'b0;
   logic [PIX-1:0] pixel_data_flat;
   logic           frame_swapped;
   logic           frame_dropped;
   logic [7:0]     frame_count;

   int checks = 0;
   int errors = 0;
   int drop_cnt = 0;
   logic [7:0]     exp_count = 8'd0;
   logic [PIX-1:0] exp_front_q[$];
   logic [7:0]     exp_count_q[$];

   bitmap_frame_loader dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_bit(in_bit), .in_sof(in_sof), .vsync(vsync),
      .pixel_data_flat(pixel_data_flat), .frame_swapped(frame_swapped),
      .frame_dropped(frame_dropped), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int first_diff(input logic [PIX-1:0] a, input logic [PIX-1:0] b);
      for (int i = 0; i < PIX; i++) if (a[i] !== b[i]) return i;
      return -1;
   endfunction

   task automatic chk_front(input string tag, input logic [PIX-1:0] exp);
      checks++;
      assert (pixel_data_flat === exp) else begin
         errors++;
         $error("FAIL %s observed_ones=%0d expected_ones=%0d first_diff_bit=%0d", tag,
                $countones(pixel_data_flat), $countones(exp), first_diff(pixel_data_flat, exp));
      end
   endtask

   // Scoreboard side: every swap must match the oldest queued expectation.
   always @(negedge clk) begin
      if (frame_dropped) drop_cnt++;
      if (frame_swapped || frame_dropped)
         chk("pulses_exclusive", {31'd0, frame_swapped & frame_dropped}, 32'd0);
      if (frame_swapped) begin
         if (exp_front_q.size() == 0) begin
            chk("unexpected_swap", 32'd1, 32'd0);
         end else begin
            chk_front("swap_front", exp_front_q.pop_front());
            chk("swap_count", {24'd0, frame_count}, {24'd0, exp_count_q.pop_front()});
         end
      end
   end

   task automatic send_frame(input logic [PIX-1:0] f, input bit vs_last);
      for (int i = 0; i < PIX; i++) begin
         @(negedge clk);
         if (!in_ready) chk("ready_during_fill", {31'd0, in_ready}, 32'd1);
         in_valid = 1'b1;
         in_bit   = f[i];
         in_sof   = (i == 0);
         vsync    = vs_last && (i == PIX - 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      vsync    = 1'b0;
   endtask

   task automatic send_partial(input int n, input logic b);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_bit   = b;
         in_sof   = (i == 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic pulse_vsync(input bit expect_swap, input logic [PIX-1:0] exp);
      @(negedge clk);
      vsync = 1'b1;
      if (expect_swap) begin
         exp_count = exp_count + 8'd1;
         exp_front_q.push_back(exp);
         exp_count_q.push_back(exp_count);
      end
      @(negedge clk);
      vsync = 1'b0;
      for (int k = 0; k < 5 && exp_front_q.size() != 0; k++) @(negedge clk);
      chk("swap_seen", exp_front_q.size(), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      vsync    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset     = 1'b0;
      exp_count = 8'd0;
      chk_front("reset_front", '0);
      chk("reset_count", {24'd0, frame_count}, 32'd0);
      chk("reset_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_pulses", {30'd0, frame_swapped, frame_dropped}, 32'd0);
   endtask

   logic [PIX-1:0] alt_frame;
   logic [PIX-1:0] rnd_frame;
   logic [PIX-1:0] pat_exp;

   initial begin
      pat_exp = {7680{2'b10}};
      for (int i = 0; i < PIX; i++) alt_frame[i] = i[0];
      for (int i = 0; i < PIX; i++) rnd_frame[i] = 1'($urandom_range(0, 1));
      rnd_frame[0] = 1'b1; rnd_frame[127] = 1'b0; rnd_frame[128] = 1'b1; rnd_frame[PIX-1] = 1'b1;

      do_reset();

      // Full frame held without vsync: stream is stalled and front stays blank.
      send_frame(alt_frame, 1'b0);
      for (int c = 0; c < 100; c++) begin
         chk("pend_ready_low", {31'd0, in_ready}, 32'd0);
         if (c % 25 == 0) chk_front("pend_front_blank", '0);
         @(negedge clk);
      end
      pulse_vsync(1'b1, pat_exp);
      chk("count_after_first", {24'd0, frame_count}, 32'd1);
      chk("ready_after_swap", {31'd0, in_ready}, 32'd1);
      chk("no_drop_first", drop_cnt, 32'd0);

      // vsync while idle must not touch the front buffer.
      pulse_vsync(1'b0, '0);
      chk_front("idle_vsync_front", pat_exp);

      // Partial all-ones frame abandoned by a fresh all-zero frame.
      drop_cnt = 0;
      send_partial(500, 1'b1);
      send_frame('0, 1'b0);
      chk("drop_once", drop_cnt, 32'd1);
      pulse_vsync(1'b1, '0);
      chk("count_after_drop", {24'd0, frame_count}, 32'd2);

      // Stray non-sof beats after reset, then a frame whose last beat meets vsync.
      do_reset();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_bit = 1'b1; in_sof = 1'b0;
      end
      send_frame(rnd_frame, 1'b1);
      for (int c = 0; c < 4; c++) begin
         chk("no_swap_coincident", {31'd0, frame_swapped}, 32'd0);
         @(negedge clk);
      end
      chk_front("coincident_front_blank", '0);
      chk("coincident_ready_low", {31'd0, in_ready}, 32'd0);
      pulse_vsync(1'b1, rnd_frame);
      chk("bit_0", {31'd0, pixel_data_flat[0]}, 32'd1);
      chk("bit_127", {31'd0, pixel_data_flat[127]}, 32'd0);
      chk("bit_128", {31'd0, pixel_data_flat[128]}, 32'd1);
      chk("bit_15359", {31'd0, pixel_data_flat[PIX-1]}, 32'd1);

      // Reset mid-fill and again while pending: everything discarded.
      send_partial(8000, 1'b1);
      do_reset();
      send_frame(alt_frame, 1'b0);
      chk("pend_before_reset", {31'd0, in_ready}, 32'd0);
      drop_cnt = 0;
      do_reset();
      pulse_vsync(1'b0, '0);
      chk_front("post_reset_vsync_front", '0);
      chk("post_reset_no_drop", drop_cnt, 32'd0);
      chk("post_reset_count", {24'd0, frame_count}, 32'd0);

      repeat (3) @(negedge clk);
      chk("queue_drained", exp_front_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
